store_seq_ctrl: RTL and testbench
=================================

Name: store_seq_ctrl

Overview:
Sequencer for sub-word and word stores in the multicycle datapath. Owns the read-modify-write for sb/sh: read the target word, load it into MDR, drive the store-size merge select, then write the merged word back. A sw skips the read. Misaligned or illegal store requests raise an exception pulse and never write memory.

Parameters:
MEM_LATENCY, 1, cycles from mem_addr valid (mem_wr=0) to read data valid at MDR input; legal range 1..15.
CNT_W, 4, width of internal latency counter; must hold MEM_LATENCY.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state on the clock edge where it is sampled high
start  input  1  store request; sampled only in IDLE
store_type  input  2  00=sw, 01=sb, 10=sh, 11=illegal; sampled with start
addr_in  input  32  byte address of store; sampled with start
mem_addr  output  32  address to memory, latched addr_in
mem_wr  output  1  memory write strobe
mdr_load  output  1  load enable for MDR (captures read word)
controleSS  output  2  select for store-size merge: 00 word, 01 byte, 10 half
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse: store completed
store_exc  output  1  one-cycle pulse: misaligned/illegal request rejected

Behaviour:
- States: IDLE, READ, LOAD, WRITE, DONE, EXC. Moore outputs, decoded from state and latched registers only.
- Reset: state=IDLE, latched type=00, latched addr=0, counter=0. Outputs after reset: mem_addr=0, mem_wr=0, mdr_load=0, controleSS=00, busy=0, done=0, store_exc=0.
- IDLE: start=1 latches store_type and addr_in (mem_addr updates next cycle). Next state:
  - type 11, or sw with addr_in[1:0]!=00, or sh with addr_in[0]!=0 -> EXC.
  - sw aligned -> WRITE.
  - sb, or sh aligned -> READ; counter loaded with MEM_LATENCY-1.
  - start=0 -> stay IDLE.
- READ: mem_wr=0, mdr_load=0. Counter decrements each cycle; at 0 -> LOAD. Dwell = MEM_LATENCY cycles.
- LOAD: mdr_load=1 for exactly one cycle -> WRITE.
- WRITE: mem_wr=1 for exactly one cycle; controleSS = latched type (00/01/10) -> DONE. controleSS=00 in all other states.
- DONE: done=1 one cycle -> IDLE.
- EXC: store_exc=1 one cycle, mem_wr never asserted for this request -> IDLE.
- Latencies (start sampled at edge T, state active from T+1): sw: mem_wr at T+1, done at T+2, next start accepted at T+3. sb/sh: READ T+1..T+MEM_LATENCY, mdr_load at T+MEM_LATENCY+1, mem_wr at T+MEM_LATENCY+2, done at T+MEM_LATENCY+3. Exception: store_exc at T+1.
- start while busy=1: ignored, not queued; addr/type latches unchanged.
- mem_addr holds latched address from T+1 until the next accepted start; not changed by ignored starts.
- mem_wr, mdr_load, done, store_exc mutually exclusive; never two high in the same cycle.
- Reset mid-operation (any state): next cycle IDLE with reset values; no mem_wr, done or store_exc emitted for the aborted request. Reset wins over start in the same cycle.

Test Plan:
- sw: reset, start=1, type=00, addr=0x00000010 for one cycle -> mem_addr=0x10, mem_wr=1 with controleSS=00 at T+1, done at T+2, busy low at T+3.
- sb, MEM_LATENCY=2: start, type=01, addr=0x00000023 -> READ 2 cycles with mem_wr=0, mdr_load=1 at T+3, mem_wr=1 with controleSS=01 at T+4, done at T+5.
- Misaligned/illegal: sh addr=0x00000021 -> store_exc at T+1, no mem_wr, no done; type=11 addr=0x0 -> same; sw addr=0x2 -> same.
- start held high during sh (addr=0x40) with second address 0x80 presented while busy -> only one write, mem_addr stays 0x40, next request accepted only after DONE.
- Reset asserted in READ of an sb -> next cycle all outputs at reset values, no mem_wr/done afterwards; a fresh sw then completes normally.
- Back-to-back: sw then sh issued on the first IDLE cycle after done -> both complete, controleSS sequence 00 then 10, exactly two mem_wr pulses.

Source files
------------

// File: rtl/store_seq_ctrl_if.sv
// Request/memory-control bundle between a store requester and store_seq_ctrl.
// The requester drives start/store_type/addr_in; the controller drives the rest.
interface store_seq_ctrl_if;
  logic        start;
  logic [1:0]  store_type;
  logic [31:0] addr_in;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic        mdr_load;
  logic [1:0]  controleSS;
  logic        busy;
  logic        done;
  logic        store_exc;

  modport master (
    output start, store_type, addr_in,
    input  mem_addr, mem_wr, mdr_load, controleSS, busy, done, store_exc
  );

  modport slave (
    input  start, store_type, addr_in,
    output mem_addr, mem_wr, mdr_load, controleSS, busy, done, store_exc
  );
endinterface

// File: rtl/store_seq_ctrl.sv
// Store sequencer: read-modify-write for sb/sh, direct write for sw,
// and rejection of misaligned or illegal requests with a one-cycle exception pulse.
module store_seq_ctrl #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned CNT_W       = 4
) (
  input  logic            clk,
  input  logic            reset,
  store_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SB  = 2'b01,
    ST_SH  = 2'b10,
    ST_ILL = 2'b11
  } store_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_EXC
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        type_q;
  logic [31:0]       addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept;
  logic              exc_req;

  assign accept = (state_q == S_IDLE) && bus.start;

  // Word stores need 4-byte alignment, half stores 2-byte; bytes never misalign.
  assign exc_req = (bus.store_type == ST_ILL) ||
                   ((bus.store_type == ST_SW) && (bus.addr_in[1:0] != 2'b00)) ||
                   ((bus.store_type == ST_SH) && bus.addr_in[0]);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      type_q  <= 2'b00;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        type_q <= bus.store_type;
        addr_q <= bus.addr_in;
        cnt_q  <= CNT_W'(MEM_LATENCY - 1);
      end else if (state_q == S_READ && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves a variable unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (exc_req)                        state_d = S_EXC;
          else if (bus.store_type == ST_SW)   state_d = S_WRITE;
          else                                state_d = S_READ;
        end
      end
      S_READ:  if (cnt_q == '0) state_d = S_LOAD;
      S_LOAD:  state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_EXC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs: decoded only from state and latched registers.
  always_comb begin
    bus.mem_wr     = 1'b0;
    bus.mdr_load   = 1'b0;
    bus.controleSS = 2'b00;
    bus.done       = 1'b0;
    bus.store_exc  = 1'b0;
    bus.busy       = (state_q != S_IDLE);
    bus.mem_addr   = addr_q;
    case (state_q)
      S_LOAD:  bus.mdr_load = 1'b1;
      S_WRITE: begin
        bus.mem_wr     = 1'b1;
        bus.controleSS = type_q;
      end
      S_DONE:  bus.done      = 1'b1;
      S_EXC:   bus.store_exc = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_store_seq_ctrl.sv
// Directed bench for store_seq_ctrl with MEM_LATENCY=2; expected values are
// hand-derived cycle by cycle from the store sequencing rules.
module tb_store_seq_ctrl;

  logic clk;
  logic reset;
  int   vecs;
  int   errs;
  int   wr_cnt;
  int   wr_base;
  logic [1:0] cs_log[$];

  logic [1:0]  exc_type [3];
  logic [31:0] exc_addr [3];

  store_seq_ctrl_if bus ();

  store_seq_ctrl #(.MEM_LATENCY(2), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every write strobe and log its merge select, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_wr) begin
      wr_cnt++;
      cs_log.push_back(bus.controleSS);
    end
  end

  // {mem_wr, mdr_load, controleSS[1:0], busy, done, store_exc}
  function automatic logic [6:0] outs();
    return {bus.mem_wr, bus.mdr_load, bus.controleSS, bus.busy, bus.done, bus.store_exc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [1:0] t, input logic [31:0] a);
    bus.start      = 1'b1;
    bus.store_type = t;
    bus.addr_in    = a;
  endtask

  initial begin
    vecs = 0; errs = 0; wr_cnt = 0;
    exc_type = '{2'b10, 2'b11, 2'b00};
    exc_addr = '{32'h21, 32'h0, 32'h2};
    reset = 1'b1;
    bus.start = 1'b0; bus.store_type = 2'b00; bus.addr_in = '0;
    tick(); tick();
    check("reset_outs", 32'(outs()), 32'h0);
    check("reset_addr", bus.mem_addr, 32'h0);
    reset = 1'b0;
    tick();

    // sw aligned: write at T+1, done at T+2, idle at T+3
    request(2'b00, 32'h10);
    tick();
    bus.start = 1'b0;
    check("sw_write", 32'(outs()), 32'(7'b1_0_00_1_0_0));
    check("sw_addr", bus.mem_addr, 32'h10);
    tick();
    check("sw_done", 32'(outs()), 32'(7'b0_0_00_1_1_0));
    tick();
    check("sw_idle", 32'(outs()), 32'h0);

    // sb: READ two cycles, LOAD, WRITE with select 01, DONE
    request(2'b01, 32'h23);
    tick();
    bus.start = 1'b0;
    check("sb_read1", 32'(outs()), 32'(7'b0_0_00_1_0_0));
    tick();
    check("sb_read2", 32'(outs()), 32'(7'b0_0_00_1_0_0));
    tick();
    check("sb_load", 32'(outs()), 32'(7'b0_1_00_1_0_0));
    tick();
    check("sb_write", 32'(outs()), 32'(7'b1_0_01_1_0_0));
    check("sb_addr", bus.mem_addr, 32'h23);
    tick();
    check("sb_done", 32'(outs()), 32'(7'b0_0_00_1_1_0));
    tick();
    check("sb_idle", 32'(outs()), 32'h0);

    // misaligned sh, illegal type, misaligned sw: exception only
    wr_base = wr_cnt;
    for (int i = 0; i < 3; i++) begin
      request(exc_type[i], exc_addr[i]);
      tick();
      bus.start = 1'b0;
      check("exc_pulse", 32'(outs()), 32'(7'b0_0_00_1_0_1));
      tick();
      check("exc_idle", 32'(outs()), 32'h0);
    end
    check("exc_no_write", 32'(wr_cnt - wr_base), 32'd0);

    // sh held with start high; a second address appears while busy
    wr_base = wr_cnt;
    request(2'b10, 32'h40);
    tick();
    request(2'b00, 32'h80);
    check("hold_read_addr", bus.mem_addr, 32'h40);
    tick(); tick();
    check("hold_load", 32'(outs()), 32'(7'b0_1_00_1_0_0));
    tick();
    check("hold_write", 32'(outs()), 32'(7'b1_0_10_1_0_0));
    check("hold_write_addr", bus.mem_addr, 32'h40);
    tick();
    check("hold_done", 32'(outs()), 32'(7'b0_0_00_1_1_0));
    bus.start = 1'b0;
    tick();
    check("hold_idle", 32'(outs()), 32'h0);
    check("hold_addr_kept", bus.mem_addr, 32'h40);
    check("hold_one_write", 32'(wr_cnt - wr_base), 32'd1);
    request(2'b00, 32'h80);
    tick();
    bus.start = 1'b0;
    check("after_hold_write", 32'(outs()), 32'(7'b1_0_00_1_0_0));
    check("after_hold_addr", bus.mem_addr, 32'h80);
    tick(); tick();

    // reset during READ of an sb aborts it silently
    wr_base = wr_cnt;
    request(2'b01, 32'h5);
    tick();
    bus.start = 1'b0;
    check("abort_read", 32'(outs()), 32'(7'b0_0_00_1_0_0));
    reset = 1'b1;
    tick();
    check("abort_outs", 32'(outs()), 32'h0);
    check("abort_addr", bus.mem_addr, 32'h0);
    reset = 1'b0;
    tick(); tick(); tick();
    check("abort_quiet", 32'(outs()), 32'h0);
    check("abort_no_write", 32'(wr_cnt - wr_base), 32'd0);
    request(2'b00, 32'h8);
    tick();
    bus.start = 1'b0;
    check("fresh_sw_write", 32'(outs()), 32'(7'b1_0_00_1_0_0));
    tick();
    check("fresh_sw_done", 32'(outs()), 32'(7'b0_0_00_1_1_0));
    tick();

    // reset wins over a start in the same cycle
    reset = 1'b1;
    request(2'b00, 32'h44);
    tick();
    bus.start = 1'b0;
    reset = 1'b0;
    check("reset_beats_start", 32'(outs()), 32'h0);
    check("reset_beats_addr", bus.mem_addr, 32'h0);
    tick();

    // back-to-back: sw then sh on the first IDLE cycle after done
    wr_base = wr_cnt;
    cs_log.delete();
    request(2'b00, 32'h100);
    tick();
    bus.start = 1'b0;
    tick();
    check("b2b_sw_done", 32'(outs()), 32'(7'b0_0_00_1_1_0));
    tick();
    check("b2b_idle", 32'(outs()), 32'h0);
    request(2'b10, 32'h102);
    tick();
    bus.start = 1'b0;
    check("b2b_sh_read", 32'(outs()), 32'(7'b0_0_00_1_0_0));
    tick(); tick(); tick();
    check("b2b_sh_write", 32'(outs()), 32'(7'b1_0_10_1_0_0));
    tick();
    check("b2b_sh_done", 32'(outs()), 32'(7'b0_0_00_1_1_0));
    tick(); tick();
    check("b2b_two_writes", 32'(wr_cnt - wr_base), 32'd2);
    check("b2b_cs_count", 32'(cs_log.size()), 32'd2);
    if (cs_log.size() == 2) begin
      check("b2b_cs_first", 32'(cs_log[0]), 32'(2'b00));
      check("b2b_cs_second", 32'(cs_log[1]), 32'(2'b10));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
